// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- decode-stage sequencing controller
//
// Purpose:
//   This block controls sequencing in the decode stage and the ID/EX buffer.
//   It keeps a small scoreboard of destination registers for instructions
//   that have left ID and have not yet written back. From that scoreboard it
//   produces three controls:
//     - stall  : hold the PC and IF/ID
//     - bubble : load zero controls into ID/EX
//     - flush  : invalidate IF/ID
//   These are raised for RAW hazards and for taken branches/jumps.
//   A drain handshake lets a halt or interrupt requester empty the pipeline.
//
// Optional feature (macro FWD_EN):
//   When FWD_EN is defined, EX/MEM forwarding is assumed to exist. Only a
//   load-use hit on the youngest scoreboard entry then counts as a hazard.
//   When it is undefined, a hit on any pending writer stalls.
//
// Ports:
//   clk, rst_n        pipeline clock (rising edge), async active-low reset
//   id_valid          ID holds a real instruction
//   id_rs / id_rt     source registers, qualified by id_rs_used / id_rt_used
//   id_rd, id_regw    destination register and its write enable
//   id_memr           ID instruction is a load
//   ex_taken          branch/jump resolved taken in EX
//   drain_req         request to empty the pipeline
//   stall, bubble     hold IF/ID+PC, zero the ID/EX controls
//   flush             squash IF/ID
//   drain_ack         pipeline empty and issue frozen
//   stall_count       saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW       = 6,
  parameter int WB_LAT       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regw,
  input  logic              id_memr,
  input  logic              ex_taken,
  input  logic              drain_req,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              drain_ack,
  output logic [15:0]       stall_count
);

  // The flush counter only ever holds values 1..FLUSH_CYCLES-1.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IDLE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       stall_count_q, stall_count_d;

  // Scoreboard: entry 0 is the instruction that left ID most recently.
  logic [WB_LAT-1:0] sb_vld_q, sb_vld_d;
  logic [WB_LAT-1:0] sb_load_q, sb_load_d;
  logic [REG_AW-1:0] sb_rd_q [WB_LAT];
  logic [REG_AW-1:0] sb_rd_d [WB_LAT];

  logic rs_hit, rt_hit, hazard, issue;
  logic stall_c, bubble_c, flush_c, ack_c;

  // ---------------------------------------------------------------------
  // Hit detection
  // ---------------------------------------------------------------------
`ifdef FWD_EN
  // With forwarding, every ALU result is bypassed in time. Only a load
  // result that is still in EX (entry 0) arrives too late to be forwarded.
  assign rs_hit = sb_vld_q[0] & sb_load_q[0] & (sb_rd_q[0] == id_rs);
  assign rt_hit = sb_vld_q[0] & sb_load_q[0] & (sb_rd_q[0] == id_rt);
`else
  logic [WB_LAT-1:0] rs_match, rt_match;

  for (genvar gi = 0; gi < WB_LAT; gi++) begin : g_match
    assign rs_match[gi] = sb_vld_q[gi] & (sb_rd_q[gi] == id_rs);
    assign rt_match[gi] = sb_vld_q[gi] & (sb_rd_q[gi] == id_rt);
  end

  assign rs_hit = |rs_match;
  assign rt_hit = |rt_match;
`endif

  assign hazard = id_valid & ((id_rs_used & rs_hit) | (id_rt_used & rt_hit));

  // The oldest entry is only ever shifted out. Its load flag (and, with
  // forwarding, its rd) has no further reader.
  logic unused_ok;
  assign unused_ok = ^{sb_load_q[WB_LAT-1], sb_rd_q[WB_LAT-1]};

  // ---------------------------------------------------------------------
  // Sequencing FSM: next state and combinational controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    stall_c       = 1'b0;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    ack_c         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_RELOAD;
          end
        end else if (drain_req) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = ST_DRAIN;
        end else if (hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
          end
        end
      end

      ST_FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (ex_taken) begin
          // A newer taken branch restarts the squash window.
          cnt_d = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DRAIN: begin
        bubble_c = 1'b1;
        if (ex_taken) begin
          // The redirect wins over the drain. IF/ID is squashed instead of
          // held, so stall stays low.
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          stall_c = 1'b1;
          if (!drain_req) begin
            state_d = ST_RUN;
          end else if (sb_vld_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        ack_c    = 1'b1;
        if (!drain_req) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Scoreboard shift
  // ---------------------------------------------------------------------
  // A flushed or stalled ID instruction never reaches EX, so it must not
  // be recorded.
  assign issue = id_valid & id_regw & ~stall_c & ~bubble_c;

  always_comb begin
    sb_vld_d  = '0;
    sb_load_d = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      sb_rd_d[i] = '0;
    end
    sb_vld_d[0]  = issue;
    sb_load_d[0] = id_memr;
    sb_rd_d[0]   = id_rd;
    for (int i = 1; i < WB_LAT; i++) begin
      sb_vld_d[i]  = sb_vld_q[i-1];
      sb_load_d[i] = sb_load_q[i-1];
      sb_rd_d[i]   = sb_rd_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
      sb_vld_q      <= '0;
      sb_load_q     <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        sb_rd_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      sb_vld_q      <= sb_vld_d;
      sb_load_q     <= sb_load_d;
      for (int i = 0; i < WB_LAT; i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  // While reset is held, the controls are forced low whatever the inputs
  // are doing.
  assign stall       = rst_n & stall_c;
  assign bubble      = rst_n & bubble_c;
  assign flush       = rst_n & flush_c;
  assign drain_ack   = rst_n & ack_c;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl
//
// Structure:
//   - A driver issues one input vector per cycle, just after the rising
//     edge.
//   - A behavioural model, written in terms of pending writers and
//     remaining flush cycles, predicts that cycle's outputs. The
//     prediction is queued.
//   - A monitor pops each prediction and compares it on the falling edge.
//
// Stimulus:
//   Directed scenarios run first:
//     - RAW stall
//     - taken branch
//     - taken branch together with a hazard
//     - drain
//     - reset mid-flush
//   Randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_AW = 6;
  localparam int WB_LAT = 3;
  localparam int FLUSH_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_rs_used = 1'b0;
  logic              id_rt_used = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_regw = 1'b0;
  logic              id_memr = 1'b0;
  logic              ex_taken = 1'b0;
  logic              drain_req = 1'b0;
  logic              stall, bubble, flush, drain_ack;
  logic [15:0]       stall_count;

  hazard_ctrl #(
    .REG_AW(REG_AW), .WB_LAT(WB_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regw(id_regw), .id_memr(id_memr), .ex_taken(ex_taken),
    .drain_req(drain_req), .stall(stall), .bubble(bubble), .flush(flush),
    .drain_ack(drain_ack), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        ack;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [REG_AW-1:0] rd;
    bit                load;
    int                age;   // whole cycles since the writer left ID
  } wr_t;

  wr_t m_pend[$];
  int  m_flush_left = 0;   // forced flush cycles still owed, current included
  bit  m_draining   = 0;
  bit  m_drained    = 0;
  int  m_count      = 0;

  function automatic bit m_hit(logic [REG_AW-1:0] a);
    foreach (m_pend[i]) begin
`ifdef FWD_EN
      if (m_pend[i].age == 0 && m_pend[i].load && m_pend[i].rd == a) return 1;
`else
      if (m_pend[i].rd == a) return 1;
`endif
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_flush_left = 0;
    m_draining   = 0;
    m_drained    = 0;
    m_count      = 0;
  endtask

  // Predict outputs for the inputs now applied, then advance one edge.
  task automatic model_step(output exp_t e);
    wr_t nq[$];
    bit  hz;
    e.stall  = 0;
    e.bubble = 0;
    e.flush  = 0;
    e.ack    = 0;
    e.cnt    = 16'(m_count);
    e.cyc    = cyc_no;

    if (!rst_n) begin
      model_reset();
      e.cnt = 16'd0;
      return;
    end

    hz = id_valid && ((id_rs_used && m_hit(id_rs)) || (id_rt_used && m_hit(id_rt)));

    if (m_flush_left > 0) begin
      e.flush  = 1;
      e.bubble = 1;
      m_flush_left = ex_taken ? FLUSH_CYCLES - 1 : m_flush_left - 1;
    end else if (m_drained) begin
      e.stall  = 1;
      e.bubble = 1;
      e.ack    = 1;
      if (!drain_req) m_drained = 0;
    end else if (m_draining) begin
      if (ex_taken) begin
        e.flush  = 1;
        e.bubble = 1;
        m_flush_left = FLUSH_CYCLES - 1;
        m_draining   = 0;
      end else begin
        e.stall  = 1;
        e.bubble = 1;
        if (!drain_req) begin
          m_draining = 0;
        end else if (m_pend.size() == 0) begin
          m_draining = 0;
          m_drained  = 1;
        end
      end
    end else begin
      if (ex_taken) begin
        e.flush  = 1;
        e.bubble = 1;
        m_flush_left = FLUSH_CYCLES - 1;
      end else if (drain_req) begin
        e.stall    = 1;
        e.bubble   = 1;
        m_draining = 1;
      end else if (hz) begin
        e.stall  = 1;
        e.bubble = 1;
        if (m_count < 65535) m_count++;
      end
    end

    // Age the in-flight writers. A writer leaves once it has been pending
    // for WB_LAT cycles.
    foreach (m_pend[i]) begin
      if (m_pend[i].age + 1 < WB_LAT) begin
        wr_t w = m_pend[i];
        w.age++;
        nq.push_back(w);
      end
    end
    if (id_valid && id_regw && !e.stall && !e.bubble) begin
      wr_t w;
      w.rd   = id_rd;
      w.load = id_memr;
      w.age  = 0;
      nq.push_back(w);
    end
    m_pend = nq;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit v,
                       input logic [REG_AW-1:0] rs, input bit rsu,
                       input logic [REG_AW-1:0] rt, input bit rtu,
                       input logic [REG_AW-1:0] rd, input bit rw, input bit mr,
                       input bit ext, input bit dr);
    exp_t e;
    @(posedge clk);
    #1;
    cyc_no++;
    rst_n      = rst;
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_rd      = rd;
    id_regw    = rw;
    id_memr    = mr;
    ex_taken   = ext;
    drain_req  = dr;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic nop(input bit dr);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, dr);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({stall, bubble, flush, drain_ack, stall_count} !==
            {e.stall, e.bubble, e.flush, e.ack, e.cnt}) begin
          n_bad++;
          $display("FAIL outputs cyc%0d: got stall=%0b bubble=%0b flush=%0b ack=%0b cnt=%0d, expected stall=%0b bubble=%0b flush=%0b ack=%0b cnt=%0d",
                   e.cyc, stall, bubble, flush, drain_ack, stall_count,
                   e.stall, e.bubble, e.flush, e.ack, e.cnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit dr_r;

    // Reset for two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW: a writer of r5, then a reader of r5 held until it issues.
    drive(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    repeat (5) drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) nop(0);

    // Taken branch while ID holds a writer of r9, then a reader of r9.
    drive(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
    nop(0);
    drive(1, 1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
    nop(0);

    // Taken branch and hazard in the same cycle.
    drive(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) nop(0);

    // Drain with two writers in flight.
    drive(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    repeat (6) nop(1);
    repeat (2) nop(0);

    // Reset pulsed during the last flush cycle. The old writer is
    // forgotten afterwards.
    drive(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
    nop(0);

    // Randomized traffic on a small register set, so hits are frequent.
    dr_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if (dr_r) dr_r = ($urandom_range(0, 7) != 0);
      else      dr_r = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) != 0),
            REG_AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            REG_AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            REG_AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0,
            dr_r);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d predictions left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the decode stage and ID/EX buffer.
- Keeps a destination-register scoreboard of instructions in flight after ID.
- Generates stall (hold PC and IF/ID), bubble (zero the ID/EX control bits) and flush (squash IF/ID) on RAW hazards and taken branches/jumps.
- Provides a drain handshake so a halt/interrupt requester can empty the pipeline.

Parameters:
REG_AW, 6, register address width (matches the 6-bit rd/rs/rt fields)
WB_LAT, 3, cycles an issued writer stays pending after leaving ID (scoreboard depth, >=1)
FLUSH_CYCLES, 2, cycles flush/bubble stay asserted per taken branch (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source register 1
id_rt  in  REG_AW  source register 2
id_rs_used  in  1  id_rs is read
id_rt_used  in  1  id_rt is read
id_rd  in  REG_AW  destination register
id_regw  in  1  ID instruction writes id_rd
id_memr  in  1  ID instruction is a load
ex_taken  in  1  branch/jump in EX resolved taken (brz&zero | brn&neg | j)
drain_req  in  1  request to empty the pipeline
stall  out  1  hold PC and IF/ID
bubble  out  1  load zero controls into ID/EX
flush  out  1  invalidate IF/ID
drain_ack  out  1  pipeline empty, issue frozen
stall_count  out  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - All scoreboard entries invalid; state RUN; stall_count=0.
  - stall=bubble=flush=drain_ack=0 while reset is asserted.
  - Reset mid-flush or mid-drain abandons the operation.
- Scoreboard: shift pipeline of WB_LAT entries {valid, rd, load}.
  - Each edge: entry[i+1]<=entry[i]; entry[WB_LAT-1] is discarded.
  - entry[0] <= {1, id_rd, id_memr} iff issue = id_valid & id_regw & !stall & !bubble. Otherwise entry[0] is invalid.
- hazard (combinational) = id_valid & ((id_rs_used & hit(id_rs)) | (id_rt_used & hit(id_rt))). hit(a) is true when any valid entry has rd==a.
- States:
  - RUN:
    - ex_taken: flush=bubble=1 this cycle. If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1.
    - else drain_req: stall=bubble=1, go DRAIN.
    - else hazard: stall=bubble=1, stall_count+=1 (saturate at 0xFFFF).
  - FLUSH: flush=bubble=1, cnt-=1, return to RUN at cnt==1. ex_taken seen again reloads cnt=FLUSH_CYCLES-1.
  - DRAIN: stall=bubble=1.
    - ex_taken: go FLUSH, or RUN if FLUSH_CYCLES==1, with flush=bubble=1.
    - drain_req low: RUN.
    - all entries invalid: IDLE.
  - IDLE: stall=bubble=1, drain_ack=1. Go to RUN the cycle after drain_req falls. ex_taken is ignored.
- Priority: ex_taken > drain_req > hazard. A flushed or stalled ID instruction never enters the scoreboard.
- Outputs are combinational from the registered state and the current inputs, so stall/flush are asserted in the same cycle as their cause.

Optional Feature:
FWD_EN:
- Defined: EX/MEM forwarding exists. hazard counts only a load-use hit: entry[0] valid & load & rd match. Every other hit is ignored.
- Undefined: all WB_LAT entries are checked as above.

Test Plan:
1. rst_n pulsed low during FLUSH (cnt=1) -> outputs 0 immediately; after release, state RUN and an id_rs matching a prior rd gives no stall.
2. Default config, WB_LAT=3: issue rd=5 regw, next instruction id_rs=5 used -> stall=bubble=1 for exactly 3 cycles, then issues; stall_count=3.
3. FWD_EN defined: ALU producer rd=7, consumer rt=7 -> 0 stall cycles. Load producer rd=7 -> exactly 1 stall cycle; stall_count=1.
4. FLUSH_CYCLES=2: ex_taken pulsed at cycle T, ID holds regw rd=9 -> flush=bubble=1 at T and T+1. A later reader of r9 does not stall.
5. ex_taken and hazard in the same cycle -> flush=1, stall=0, stall_count unchanged.
6. Two writers in flight, drain_req held -> stall=1 each cycle; drain_ack=1 once entries empty (<=3 cycles). Drop drain_req -> next cycle RUN, drain_ack=0, stall=0.
